// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: sequential add/subtract controller. It processes one nibble
// per cycle through a shared external 4-bit CLA slice.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start, sub, a, b       operation request; sub=1 selects a-b; sampled while ready=1
//   ready                  1 when a new start can be accepted (IDLE or DONE)
//   done                   one-cycle pulse, result and flags valid
//   result, ovf, zero, neg registered result and signed-overflow/zero/negative flags
//   nib_a, nib_b, nib_cin  operand nibbles and carry-in driven to the CLA slice
//   nib_s, nib_g, nib_p    slice sum, group generate and group propagate
//
// Optional feature: define ADD_SEQ_SAT_EN to saturate result on signed overflow.
module add_seq_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             ovf,
   output logic             zero,
   output logic             neg,
   output logic [3:0]       nib_a,
   output logic [3:0]       nib_b,
   output logic             nib_cin,
   input  logic [3:0]       nib_s,
   input  logic             nib_g,
   input  logic             nib_p
);

   localparam int unsigned NIB = WIDTH / 4;
   localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             neg_q, neg_d;

   // Bit offset of the current nibble. It is sized exactly to index a WIDTH-bit vector.
   logic [CW+1:0]    lsb;
   logic [3:0]       a_nib, b_nib;
   logic             carry_out;
   logic             msb_cin;

   assign lsb       = {cnt_q, 2'b00};
   assign a_nib     = op_a_q[lsb +: 4];
   assign b_nib     = op_b_q[lsb +: 4];
   assign carry_out = nib_g | (nib_p & carry_q);
   // Carry into the top bit is recovered from the sum bit: s = a ^ b ^ c.
   assign msb_cin   = nib_s[3] ^ a_nib[3] ^ b_nib[3];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      neg_d    = neg_q;
      nib_a    = '0;
      nib_b    = '0;
      nib_cin  = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               op_a_d  = a;
               op_b_d  = sub ? ~b : b;
               carry_d = sub;
               cnt_d   = '0;
               state_d = RUN;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            nib_a             = a_nib;
            nib_b             = b_nib;
            nib_cin           = carry_q;
            result_d[lsb +: 4] = nib_s;
            carry_d           = carry_out;
            if (cnt_q == LAST) begin
               ovf_d = msb_cin ^ carry_out;
`ifdef ADD_SEQ_SAT_EN
               // On overflow, the MSB of the wrapped value has the wrong sign.
               // If that MSB is 1, the true result was a positive overflow.
               if (ovf_d) begin
                  result_d = nib_s[3] ? {1'b0, {(WIDTH-1){1'b1}}}
                                      : {1'b1, {(WIDTH-1){1'b0}}};
               end
`endif
               zero_d  = (result_d == '0);
               neg_d   = result_d[WIDTH-1];
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
         neg_q    <= neg_d;
      end
   end

   assign ready  = (state_q != RUN);
   assign done   = (state_q == DONE);
   assign result = result_q;
   assign ovf    = ovf_q;
   assign zero   = zero_q;
   assign neg    = neg_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Testbench for add_seq_ctrl (WIDTH=16). It includes a behavioural model of
// the external 4-bit CLA slice and checks against hand-computed expectations
// and an arithmetic reference model.
module tb_add_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, sub;
   logic [15:0] a, b;
   logic        ready, done, ovf, zero, neg;
   logic [15:0] result;
   logic [3:0]  nib_a, nib_b, nib_s;
   logic        nib_cin, nib_g, nib_p;

   int checks = 0;
   int errors = 0;

   add_seq_ctrl #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
      .ready(ready), .done(done), .result(result), .ovf(ovf), .zero(zero),
      .neg(neg), .nib_a(nib_a), .nib_b(nib_b), .nib_cin(nib_cin),
      .nib_s(nib_s), .nib_g(nib_g), .nib_p(nib_p)
   );

   always #5 clk = ~clk;

   // External CLA slice model.
   logic [4:0] slice_sum, slice_gen;
   always_comb begin
      slice_sum = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, nib_cin};
      slice_gen = {1'b0, nib_a} + {1'b0, nib_b};
      nib_s     = slice_sum[3:0];
      nib_g     = slice_gen[4];
      nib_p     = &(nib_a ^ nib_b);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one operation and wait (bounded) for done. lat counts edges from
   // the sampling edge up to the edge after which done is high.
   task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                        output int lat);
      @(negedge clk);
      start = 1'b1; a = ia; b = ib; sub = isub;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic check_res(input string tag, input int lat, input logic [15:0] er,
                            input logic eo, input logic ez, input logic en);
      check({tag, "_lat"}, 64'(lat), 64'd5);
      check({tag, "_res"}, 64'(result), 64'(er));
      check({tag, "_ovf"}, 64'(ovf), 64'(eo));
      check({tag, "_zero"}, 64'(zero), 64'(ez));
      check({tag, "_neg"}, 64'(neg), 64'(en));
   endtask

   initial begin
      int lat;
      int pulses;
      logic [15:0] ra, rb, er;
      logic rs, eo;

      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      #3;
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_done", 64'(done), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_flags", 64'({ovf, zero, neg}), 64'd0);
      check("rst_nib", 64'({nib_a, nib_b, nib_cin}), 64'd0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      // Plain addition.
      do_op(16'h1234, 16'h0FFF, 1'b0, lat);
      check_res("add1", lat, 16'h2233, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
      check("done_pulse_end", 64'(done), 64'd0);
      check("idle_ready", 64'(ready), 64'd1);

      // Positive overflow.
      do_op(16'h7FFF, 16'h0001, 1'b0, lat);
`ifdef ADD_SEQ_SAT_EN
      check_res("povf", lat, 16'h7FFF, 1'b1, 1'b0, 1'b0);
`else
      check_res("povf", lat, 16'h8000, 1'b1, 1'b0, 1'b1);
`endif
      // Subtraction to zero (back-to-back from DONE).
      check("b2b_done_high", 64'(done), 64'd1);
      do_op(16'h0005, 16'h0005, 1'b1, lat);
      check_res("sub_zero", lat, 16'h0000, 1'b0, 1'b1, 1'b0);
      // Negative overflow.
      do_op(16'h8000, 16'h0001, 1'b1, lat);
`ifdef ADD_SEQ_SAT_EN
      check_res("novf", lat, 16'h8000, 1'b1, 1'b0, 1'b1);
`else
      check_res("novf", lat, 16'h7FFF, 1'b1, 1'b0, 1'b0);
`endif
      @(posedge clk); #1;
      @(posedge clk); #1;

      // A second start during RUN is ignored.
      @(negedge clk);
      start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
      @(posedge clk); #1;
      a = 16'hAAAA; b = 16'h5555; sub = 1'b1;
      check("run_ready", 64'(ready), 64'd0);
      check("run_nib_a", 64'(nib_a), 64'h1);
      @(posedge clk); #1;
      start = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            pulses++;
            check("ign_res", 64'(result), 64'h3333);
         end
         @(posedge clk); #1;
      end
      check("ign_pulses", 64'(pulses), 64'd1);
      check("ign_idle_nib", 64'({nib_a, nib_b, nib_cin}), 64'd0);

      // Reset asserted during the third RUN cycle.
      @(negedge clk);
      start = 1'b1; a = 16'h1234; b = 16'h1111; sub = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("mrst_result", 64'(result), 64'd0);
      check("mrst_ready", 64'(ready), 64'd1);
      check("mrst_done", 64'(done), 64'd0);
      check("mrst_flags", 64'({ovf, zero, neg}), 64'd0);
      check("mrst_nib", 64'({nib_a, nib_b, nib_cin}), 64'd0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
         if (i == 2) rst = 1'b0;
      end
      check("mrst_nopulse", 64'(pulses), 64'd0);
      do_op(16'hFFFF, 16'h0001, 1'b0, lat);
      check_res("wrap_zero", lat, 16'h0000, 1'b0, 1'b1, 1'b0);

      // Random operations against an arithmetic reference model.
      for (int n = 0; n < 1000; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom_range(0, 1));
         if (rs) begin
            er = ra - rb;
            eo = (ra[15] != rb[15]) && (er[15] != ra[15]);
         end else begin
            er = ra + rb;
            eo = (ra[15] == rb[15]) && (er[15] != ra[15]);
         end
`ifdef ADD_SEQ_SAT_EN
         if (eo) er = ra[15] ? 16'h8000 : 16'h7FFF;
`endif
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         do_op(ra, rb, rs, lat);
         check_res("rand", lat, er, eo, (er == 16'h0000), er[15]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
